// File: rtl/cascade_event_arbiter.sv
// Merges ML and rule-engine event strobes into one ordered stream through a small FIFO,
// with overflow drop counting and a timed flush that also clears the downstream detector.
module cascade_event_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rule_alert_any,
    input  logic [2:0]                 rule_alert_type,
    input  logic                       ml_valid,
    input  logic [2:0]                 ml_class,
    input  logic [7:0]                 ml_confidence,
    input  logic                       flush_req,
    output logic                       out_valid,
    output logic [2:0]                 out_code,
    output logic [7:0]                 out_conf,
    output logic                       out_src,
    output logic                       det_flush,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [7:0]                 drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    typedef struct packed {
        logic [2:0] code;
        logic [7:0] conf;
        logic       src;
    } entry_t;

    state_t          state;
    logic [CW-1:0]   flush_cnt;
    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [LW-1:0]   level;

    logic            ml_ev;
    logic            rule_ev;
    logic            pop;
    logic [LW-1:0]   free;
    logic [1:0]      want;
    logic [1:0]      n_wr;
    logic [1:0]      drops;
    logic [8:0]      drop_sum;
    logic [7:0]      drop_next;
    entry_t          ml_entry;
    entry_t          rule_entry;
    entry_t          first_entry;

    always_comb begin
        ml_ev       = ml_valid && (ml_class != '0);
        // A rule event duplicating the same-cycle ML code is merged away, not dropped
        rule_ev     = rule_alert_any && !(ml_ev && (rule_alert_type == ml_class));
        pop         = (state == RUN) && (level != '0);
        free        = LW'(DEPTH) - level + LW'(pop);
        want        = {1'b0, ml_ev} + {1'b0, rule_ev};
        n_wr        = (LW'(want) <= free) ? want : free[1:0];
        drops       = want - n_wr;
        drop_sum    = {1'b0, drop_cnt} + 9'(drops);
        drop_next   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        ml_entry    = '{code: ml_class, conf: ml_confidence, src: 1'b1};
        rule_entry  = '{code: rule_alert_type, conf: 8'h00, src: 1'b0};
        first_entry = ml_ev ? ml_entry : rule_entry;
    end

    always_ff @(posedge clk) begin
        if ((state == RUN) && !flush_req) begin
            if (n_wr != 2'd0) mem[wr_ptr] <= first_entry;
            if (n_wr == 2'd2) mem[wr_ptr + AW'(1)] <= rule_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            flush_cnt <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_conf  <= '0;
            out_src   <= 1'b0;
            det_flush <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (flush_req) begin
                        state     <= FLUSH;
                        flush_cnt <= CW'(FLUSH_CYCLES);
                        det_flush <= 1'b1;
                        out_valid <= 1'b0;
                        rd_ptr    <= '0;
                        wr_ptr    <= '0;
                        level     <= '0;
                    end else begin
                        out_valid <= pop;
                        if (pop) begin
                            out_code <= mem[rd_ptr].code;
                            out_conf <= mem[rd_ptr].conf;
                            out_src  <= mem[rd_ptr].src;
                            rd_ptr   <= rd_ptr + AW'(1);
                        end
                        wr_ptr   <= wr_ptr + AW'(n_wr);
                        level    <= level + LW'(n_wr) - LW'(pop);
                        drop_cnt <= drop_next;
                    end
                end
                FLUSH: begin
                    out_valid <= 1'b0;
                    if (flush_req) begin
                        flush_cnt <= CW'(FLUSH_CYCLES);
                    end else if (flush_cnt <= CW'(1)) begin
                        state     <= RUN;
                        det_flush <= 1'b0;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - CW'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign busy       = (state == FLUSH) || (level != '0);
    assign fifo_level = level;

endmodule

// File: tb/tb_cascade_event_arbiter.sv
// Directed and randomized bench for cascade_event_arbiter against a queue-based reference model.
module tb_cascade_event_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned FC    = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rule_alert_any = 1'b0;
    logic [2:0] rule_alert_type = '0;
    logic       ml_valid = 1'b0;
    logic [2:0] ml_class = '0;
    logic [7:0] ml_confidence = '0;
    logic       flush_req = 1'b0;
    logic       out_valid;
    logic [2:0] out_code;
    logic [7:0] out_conf;
    logic       out_src;
    logic       det_flush;
    logic       busy;
    logic [2:0] fifo_level;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    cascade_event_arbiter #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n),
        .rule_alert_any(rule_alert_any), .rule_alert_type(rule_alert_type),
        .ml_valid(ml_valid), .ml_class(ml_class), .ml_confidence(ml_confidence),
        .flush_req(flush_req),
        .out_valid(out_valid), .out_code(out_code), .out_conf(out_conf), .out_src(out_src),
        .det_flush(det_flush), .busy(busy), .fifo_level(fifo_level), .drop_cnt(drop_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of {code, conf, src} plus a flush countdown
    logic [11:0] mq[$];
    int          m_flush;
    int          m_drops;
    logic        m_valid;
    logic [2:0]  m_code;
    logic [7:0]  m_conf;
    logic        m_src;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_flush = 0;
        m_drops = 0;
        m_valid = 1'b0;
        m_code  = '0;
        m_conf  = '0;
        m_src   = 1'b0;
    endfunction

    function automatic void model_step();
        logic [11:0] ev[$];
        logic [11:0] e;
        int          lost;
        bit          ml_ev;
        if (m_flush == 0) begin
            if (flush_req) begin
                mq.delete();
                m_flush = FC;
                m_valid = 1'b0;
            end else begin
                m_valid = (mq.size() > 0);
                if (m_valid) begin
                    e = mq.pop_front();
                    {m_code, m_conf, m_src} = e;
                end
                ml_ev = ml_valid && (ml_class != 0);
                if (ml_ev) ev.push_back({ml_class, ml_confidence, 1'b1});
                if (rule_alert_any && !(ml_ev && rule_alert_type == ml_class))
                    ev.push_back({rule_alert_type, 8'h00, 1'b0});
                lost = 0;
                foreach (ev[i]) begin
                    if (mq.size() < DEPTH) mq.push_back(ev[i]);
                    else lost++;
                end
                m_drops = (m_drops + lost > 255) ? 255 : m_drops + lost;
            end
        end else begin
            m_valid = 1'b0;
            if (flush_req) m_flush = FC;
            else m_flush--;
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, out_valid, m_valid);
        chk({tag, ".code"},  out_code,  m_code);
        chk({tag, ".conf"},  out_conf,  m_conf);
        chk({tag, ".src"},   out_src,   m_src);
        chk({tag, ".det"},   det_flush, m_flush > 0);
        chk({tag, ".busy"},  busy,      (m_flush > 0) || (mq.size() > 0));
        chk({tag, ".level"}, fifo_level, mq.size());
        chk({tag, ".drops"}, drop_cnt,  m_drops);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input bit mv, input logic [2:0] mc, input logic [7:0] mf,
                          input bit rv, input logic [2:0] rt, input bit fr);
        ml_valid = mv; ml_class = mc; ml_confidence = mf;
        rule_alert_any = rv; rule_alert_type = rt; flush_req = fr;
    endtask

    task automatic idle();
        set_in(0, 3'd0, 8'h00, 0, 3'd0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Single ML event
        set_in(1, 3'd3, 8'h40, 0, 3'd0, 0);
        tick("r035_wr");
        idle();
        tick("r035_out");
        chk("r035_valid", out_valid, 1);
        chk("r035_code", out_code, 3);
        chk("r035_conf", out_conf, 8'h40);
        chk("r035_src", out_src, 1);
        tick("r035_done");
        chk("r035_level", fifo_level, 0);

        // Dual event, distinct codes: ML then rule
        set_in(1, 3'd2, 8'h11, 1, 3'd3, 0);
        tick("r036_wr");
        idle();
        tick("r036_o1");
        chk("r036_first", {out_valid, out_code, out_src}, {1'b1, 3'd2, 1'b1});
        tick("r036_o2");
        chk("r036_second", {out_valid, out_code, out_conf, out_src}, {1'b1, 3'd3, 8'h00, 1'b0});
        tick("r036_done");

        // Dual event, equal codes: merged
        set_in(1, 3'd5, 8'h77, 1, 3'd5, 0);
        tick("r037_wr");
        idle();
        tick("r037_o1");
        chk("r037_out", {out_valid, out_code, out_src}, {1'b1, 3'd5, 1'b1});
        tick("r037_o2");
        chk("r037_single", out_valid, 0);
        chk("r037_drops", drop_cnt, 0);

        // Four back-to-back dual events
        for (int i = 0; i < 4; i++) begin
            set_in(1, 3'(i + 1), 8'(8'h20 + i), 1, 3'((i + 4) % 8), 0);
            tick("r038_burst");
        end
        chk("r038_full", fifo_level, 4);
        chk("r038_drops", drop_cnt, 1);
        idle();
        repeat (6) tick("r038_drain");

        // Flush with entries queued; inputs during flush are ignored
        set_in(1, 3'd1, 8'h01, 1, 3'd2, 0);
        tick("r039_q1");
        tick("r039_q2");
        chk("r039_queued", fifo_level, 3);
        set_in(1, 3'd4, 8'h44, 1, 3'd6, 1);
        tick("r039_flush");
        chk("r039_level0", fifo_level, 0);
        chk("r039_det1", det_flush, 1);
        set_in(1, 3'd4, 8'h44, 1, 3'd6, 0);
        tick("r039_hold");
        chk("r039_det2", det_flush, 1);
        tick("r039_exit");
        chk("r039_det_off", det_flush, 0);
        set_in(1, 3'd6, 8'h66, 0, 3'd0, 0);
        tick("r039_new");
        idle();
        tick("r039_new_out");
        chk("r039_resume", {out_valid, out_code}, {1'b1, 3'd6});

        // Saturating drop counter
        for (int i = 0; i < 300; i++) begin
            set_in(1, 3'd1, 8'(i), 1, 3'd2, 0);
            tick("r040_sat");
        end
        chk("r040_drop255", drop_cnt, 255);
        idle();
        repeat (6) tick("r040_drain");
        chk("r040_stays", drop_cnt, 255);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom),
                   $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                   ($urandom_range(0, 31) == 0));
            tick("rand");
        end

        // Asynchronous reset in the middle of a flush
        set_in(1, 3'd2, 8'h22, 0, 3'd0, 1);
        tick("rst_enter_flush");
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        chk("rst_det", det_flush, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1, 3'd7, 8'h99, 0, 3'd0, 0);
        tick("rst_wr");
        idle();
        tick("rst_out");
        chk("rst_first_event", {out_valid, out_code, out_conf, out_src}, {1'b1, 3'd7, 8'h99, 1'b1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cascade_event_arbiter.md
CASCADE_EVENT_ARBITER -- requirements
Module: cascade_event_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, minimum 2.
REQ-002 Parameter FLUSH_CYCLES, default 2, cycles det_flush is held per flush; minimum 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rule_alert_any  input  1  rule-engine event strobe, one cycle per event.
REQ-006 rule_alert_type  input  3  rule event code, valid with rule_alert_any.
REQ-007 ml_valid  input  1  ML result strobe; it is an event only when ml_class != 0.
REQ-008 ml_class  input  3  ML class code.
REQ-009 ml_confidence  input  8  ML confidence, sampled with ml_valid.
REQ-010 flush_req  input  1  request to clear the arbiter and the downstream history.
REQ-011 out_valid  output  1  one merged event presented to the cascade detector this cycle.
REQ-012 out_code  output  3  merged event code.
REQ-013 out_conf  output  8  event confidence: ML confidence, or 0 for rule events.
REQ-014 out_src  output  1  event source: 1 = ML, 0 = rule.
REQ-015 det_flush  output  1  drives the detector's flush input.
REQ-016 busy  output  1  high in FLUSH, or when the FIFO is non-empty.
REQ-017 fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-018 drop_cnt  output  8  saturating count of events lost to overflow.

Function
REQ-019 Event sources shall be as follows: ML event = ml_valid && ml_class != 0; rule event = rule_alert_any.
REQ-020 Both events in one cycle shall be written to the FIFO as two entries, ML entry first (older) and rule entry second.
REQ-021 If both events occur in one cycle with equal codes, only the ML entry shall be written; this is not counted as a drop.
REQ-022 Each cycle, at most one entry shall be popped and registered onto out_code/out_conf/out_src, with out_valid=1 for exactly that cycle; out_valid=0 and out_code/out_conf/out_src hold when nothing is popped.
REQ-023 Latency shall be as follows: an event written into an empty FIFO at edge N shall be presented with out_valid=1 in the cycle after edge N+1; a pop and writes in the same cycle shall both take effect, with level_next = level + writes - pop.
REQ-024 Free space shall be computed after accounting for the same-cycle pop.
REQ-025 With one free slot and two events, the ML event shall be written, the rule event dropped, and drop_cnt incremented by 1.
REQ-026 With zero free slots, every arriving event shall be dropped, and drop_cnt incremented by the number dropped (1 or 2), saturating at 255.
REQ-027 Read/write pointers shall wrap modulo DEPTH; fifo_level shall never exceed DEPTH.
REQ-028 The FSM shall have states RUN and FLUSH; reset state is RUN.
REQ-029 RUN -> FLUSH shall occur on flush_req=1; at that edge the FIFO is emptied (level 0, pointers 0), inputs that cycle are discarded uncounted, and the flush counter loads FLUSH_CYCLES.
REQ-030 In FLUSH, det_flush=1, out_valid=0, and all inputs shall be discarded without counting; the counter decrements each cycle, and the FSM returns to RUN after FLUSH_CYCLES cycles.
REQ-031 flush_req while in FLUSH shall reload the counter to FLUSH_CYCLES.
REQ-032 drop_cnt shall be cleared only by reset; flush shall not clear it.

Reset
REQ-033 On rst_n=0, asynchronously: FIFO empty, fifo_level=0, out_valid=0, out_code=0, out_conf=0, out_src=0, det_flush=0, busy=0, drop_cnt=0, state RUN.
REQ-034 Reset asserted mid-flush or mid-burst shall abandon all queued entries; the first event after release follows REQ-023.

Verification
REQ-035 Single ML event, class 3, conf 0x40, into an empty FIFO -> one cycle later out_valid=1, out_code=3, out_conf=0x40, out_src=1; fifo_level returns to 0.
REQ-036 Same cycle: ML class 2 and rule type 3 -> two consecutive out_valid cycles: (2, src 1), then (3, src 0, conf 0).
REQ-037 Same cycle: ML class 5 and rule type 5 -> a single output (5, src 1); drop_cnt unchanged.
REQ-038 DEPTH=4, dual events for 4 consecutive cycles -> level saturates at 4, drops are counted per REQ-025/026 (concrete total checked against the model), and outputs preserve order.
REQ-039 flush_req pulse with 3 entries queued -> next cycle level=0, det_flush high for exactly 2 cycles with out_valid=0, inputs ignored, then normal operation.
REQ-040 300 dropped events -> drop_cnt=255 and stays 255; async reset mid-FLUSH -> all outputs 0 immediately.
